uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Serial transmitter stage that consumes the byte stream produced by the test-pattern generator: 8-bit data plus a write strobe.
- Serialises each accepted byte as a UART frame: start bit, 8 data bits LSB first, optional parity, stop bit(s).
- Runs on the oversampled baud clock from the clock divider, which runs at OSR × baud rate.
- Drives the board TX pin and reports busy/complete status back to the source.

Parameters:
- OSR, 16: clk cycles per serial bit (oversample ratio); legal values 4..64.
- PARITY_EN, 1: 1 = insert a parity bit after the data bits; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity; 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk, input, 1: oversampled baud clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- datain, input, 8: byte to transmit; sampled only on an accepted request.
- wrsig, input, 1: write strobe; a request is its rising edge.
- tx, output, 1: serial line; idles high.
- idle, output, 1: 1 = ready to accept a request; 0 = frame in progress.
- done, output, 1: one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - tx=1, idle=1, done=0.
  - State = IDLE; all counters = 0; shift register = 0; wrsig_d = 0.
- Request detection:
  - wrsig_d is a register holding the previous-cycle wrsig.
  - A request is wrsig=1 AND wrsig_d=0 at a clk edge.
  - A wrsig held high produces exactly one request.
  - wrsig already high on the first edge after reset counts as a request, because wrsig_d resets to 0.
- Acceptance:
  - A request is accepted only at an edge where state=IDLE.
  - Requests arriving while busy are dropped, not queued.
- Accept edge (E0), in the same edge:
  - datain is latched.
  - Parity is computed: XOR of the 8 bits, inverted if PARITY_ODD.
  - State goes to START; tx<=0 and idle<=0 are registered outputs.
- State sequence: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- Bit timing:
  - Each bit holds tx constant for exactly OSR cycles.
  - A bit-cycle counter counts 0..OSR-1; the next bit is driven at the edge where it wraps.
- DATA state:
  - Bit index 0..7; tx = data[index], LSB first.
  - Leaves after bit 7's OSR cycles.
- STOP state:
  - tx=1 for STOP_BITS*OSR cycles.
  - At the edge ending the final stop period: state=IDLE, idle<=1, done<=1 for one cycle; tx stays 1.
- Frame length: F = (10 + PARITY_EN + STOP_BITS - 1) * OSR cycles from E0 to idle returning to 1. Defaults give F = 11*16 = 176.
- Back-to-back frames:
  - A request may be accepted at the first edge where idle=1 is already registered, i.e. the cycle after done.
  - A request coinciding with the done edge is dropped.
  - The minimum request period for lossless streaming is F+1 cycles.
  - With the generator's 255-cycle period, defaults leave 79 idle cycles between frames.
- datain changes after E0 do not affect the frame in flight.
- Reset mid-frame: tx=1 and idle=1 immediately; the partial frame is abandoned and no done pulse is produced.
- Counter widths: bit-cycle counter is ceil(log2(OSR)) bits; bit index is 3 bits; stop counter is 1 bit.

Test Plan:
- Defaults, datain=0x55, one-cycle wrsig:
  - tx = 0 (start), then 1,0,1,0,1,0,1,0, then parity 0, then stop 1; each level 16 cycles.
  - idle low for 176 cycles; done pulses once at cycle 176.
- datain=0x01, PARITY_EN=1:
  - Even parity: parity bit = 1.
  - PARITY_ODD=1: parity bit = 0.
  - PARITY_EN=0, STOP_BITS=2: frame is 176 cycles with 32 cycles of stop.
- wrsig held high for 300 cycles with datain=0xA3: exactly one frame, one done pulse; no second frame after idle returns.
- Second wrsig rising edge 50 cycles into a frame (datain=0xFF): ignored; the line carries only the first byte; one done pulse.
- rst_n pulsed low at cycle 80 of a 0x00 frame:
  - tx=1 and idle=1 within the reset; no done pulse.
  - A subsequent request for 0x3C transmits a correct full frame.
- Generator-style stimulus, wrsig every 255 cycles with datain 0x00,0x01,0x02:
  - Three complete frames, each starting exactly 255 cycles apart.
  - Decoded bytes match the inputs; three done pulses.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//
// UART transmitter running on an oversampled baud clock (OSR clk cycles per
// serial bit). A rising edge on wrsig while idle latches datain and sends one
// frame: start bit, 8 data bits LSB first, optional parity bit, then one or
// two stop bits. Requests that arrive mid-frame are dropped, not queued.
//
// Ports:
//   clk    - oversampled baud clock, rising-edge active
//   rst_n  - asynchronous active-low reset
//   datain - byte to send, sampled only on the accepting edge
//   wrsig  - write strobe; its rising edge is a transmit request
//   tx     - serial line, idles high
//   idle   - 1 when a new request can be accepted
//   done   - single-cycle pulse as the last stop bit finishes

module uart_tx_frame #(
    parameter int OSR        = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] datain,
    input  logic       wrsig,
    output logic       tx,
    output logic       idle,
    output logic       done
);

    localparam int            CW       = $clog2(OSR);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OSR - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);
    localparam bit            HAS_PAR  = (PARITY_EN != 0);
    localparam bit            TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] bit_cnt, bit_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic          stop_cnt, stop_cnt_next;
    logic [7:0]    shreg, shreg_next;
    logic          parity_bit, parity_next;
    logic          wrsig_d;
    logic          tx_next, idle_next, done_next;
    logic          request;
    logic          bit_wrap;

    assign request  = wrsig & ~wrsig_d;
    assign bit_wrap = (bit_cnt == CNT_MAX);

    // State and datapath registers. tx/idle/done are registered so the pin
    // never glitches; every next value comes from the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            wrsig_d    <= 1'b0;
            tx         <= 1'b1;
            idle       <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            bit_idx    <= bit_idx_next;
            stop_cnt   <= stop_cnt_next;
            shreg      <= shreg_next;
            parity_bit <= parity_next;
            wrsig_d    <= wrsig;
            tx         <= tx_next;
            idle       <= idle_next;
            done       <= done_next;
        end
    end

    // Next-state and output logic. The next bit level is always decided at
    // the edge where the bit-cycle counter wraps, so each level lasts
    // exactly OSR cycles. The shift register moves right once per data bit,
    // so shreg[1] is the bit that follows the one currently on the line.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_wrap ? '0 : bit_cnt + 1'b1;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;
        shreg_next    = shreg;
        parity_next   = parity_bit;
        tx_next       = tx;
        idle_next     = idle;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                bit_cnt_next = '0;
                if (request) begin
                    shreg_next    = datain;
                    parity_next   = (^datain) ^ ODD_BIT;
                    bit_idx_next  = '0;
                    stop_cnt_next = 1'b0;
                    state_next    = START;
                    tx_next       = 1'b0;
                    idle_next     = 1'b0;
                end
            end

            START: begin
                if (bit_wrap) begin
                    state_next = DATA;
                    tx_next    = shreg[0];
                end
            end

            DATA: begin
                if (bit_wrap) begin
                    if (bit_idx == 3'd7) begin
                        if (HAS_PAR) begin
                            state_next = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shreg_next   = {1'b0, shreg[7:1]};
                        tx_next      = shreg[1];
                    end
                end
            end

            PARITY: begin
                if (bit_wrap) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end

            STOP: begin
                if (bit_wrap) begin
                    if (TWO_STOP && !stop_cnt) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                        idle_next  = 1'b1;
                        done_next  = 1'b1;
                        tx_next    = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                idle_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//
// Self-checking bench for uart_tx_frame. Three instances share the inputs:
// defaults (even parity, one stop), odd parity, and no parity with two stop
// bits. A wrsig/datain plan is played out cycle by cycle while all outputs
// are recorded; expected waveforms, decoded bytes and frame timing are then
// derived from hand-computed values and compared.

module tb_uart_tx_frame;

    localparam int OSR   = 16;
    localparam int FRAME = 176;
    localparam int TRACE = 1024;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       wrsig  = 1'b0;
    logic [7:0] datain = 8'h00;

    logic txD, idleD, doneD;
    logic txO, idleO, doneO;
    logic txN, idleN, doneN;

    uart_tx_frame #(.OSR(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dutDefault (
        .clk(clk), .rst_n(rst_n), .datain(datain), .wrsig(wrsig),
        .tx(txD), .idle(idleD), .done(doneD)
    );

    uart_tx_frame #(.OSR(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dutOdd (
        .clk(clk), .rst_n(rst_n), .datain(datain), .wrsig(wrsig),
        .tx(txO), .idle(idleO), .done(doneO)
    );

    uart_tx_frame #(.OSR(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dutNoPar (
        .clk(clk), .rst_n(rst_n), .datain(datain), .wrsig(wrsig),
        .tx(txN), .idle(idleN), .done(doneN)
    );

    always #5 clk = ~clk;

    logic             wrPlan   [0:TRACE];
    logic [7:0]       dataPlan [0:TRACE];
    logic [TRACE-1:0] trTxD, trIdleD, trDoneD;
    logic [TRACE-1:0] trTxO, trIdleO, trDoneO;
    logic [TRACE-1:0] trTxN, trIdleN, trDoneN;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [7:0] data;
        logic       parEven;
    } vector_t;

    vector_t vectors [6];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic clearPlan();
        for (int k = 0; k <= TRACE; k++) begin
            wrPlan[k]   = 1'b0;
            dataPlan[k] = 8'hC6;
        end
    endtask

    task automatic addPulse(input int k, input logic [7:0] d);
        wrPlan[k]   = 1'b1;
        dataPlan[k] = d;
    endtask

    // Entered at a falling edge. wrPlan[k]/dataPlan[k] are the input values
    // present at rising edge k; trace entry c is sampled on the falling edge
    // right after rising edge c.
    task automatic applyStimulus(input int n);
        trTxD = '0; trIdleD = '0; trDoneD = '0;
        trTxO = '0; trIdleO = '0; trDoneO = '0;
        trTxN = '0; trIdleN = '0; trDoneN = '0;
        wrsig  = wrPlan[0];
        datain = dataPlan[0];
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            trTxD[c] = txD; trIdleD[c] = idleD; trDoneD[c] = doneD;
            trTxO[c] = txO; trIdleO[c] = idleO; trDoneO[c] = doneO;
            trTxN[c] = txN; trIdleN[c] = idleN; trDoneN[c] = doneN;
            wrsig  = wrPlan[c + 1];
            datain = dataPlan[c + 1];
        end
    endtask

    function automatic logic expTx(input logic [7:0] d, input logic parBit,
                                   input bit parEn, input int off);
        int b;
        b = off / OSR;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b - 1];
        if (parEn && b == 9) return parBit;
        return 1'b1;
    endfunction

    function automatic int waveErrs(input logic [TRACE-1:0] t, input int start,
                                    input logic [7:0] d, input logic parBit,
                                    input bit parEn, input int frameLen);
        int errs;
        errs = 0;
        for (int off = 0; off <= frameLen + 8; off++) begin
            if (start + off < TRACE && t[start + off] !== expTx(d, parBit, parEn, off))
                errs++;
        end
        return errs;
    endfunction

    function automatic int decodeAt(input logic [TRACE-1:0] t, input int start);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[i] = t[start + OSR * (i + 1) + OSR / 2];
        return int'(b);
    endfunction

    function automatic int countOnes(input logic [TRACE-1:0] t, input int from, input int to);
        int n;
        n = 0;
        for (int c = from; c <= to; c++) if (t[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int countLow(input logic [TRACE-1:0] t, input int from, input int to);
        int n;
        n = 0;
        for (int c = from; c <= to; c++) if (t[c] === 1'b0) n++;
        return n;
    endfunction

    // A frame start is a 1->0 transition of idle; idle is high before a trace.
    function automatic int frameStarts(input logic [TRACE-1:0] idl, input int from, input int to);
        int n;
        logic prev;
        n = 0;
        for (int c = from; c <= to; c++) begin
            prev = (c == 0) ? 1'b1 : idl[c - 1];
            if (prev === 1'b1 && idl[c] === 1'b0) n++;
        end
        return n;
    endfunction

    function automatic int findStart(input logic [TRACE-1:0] idl, input int from, input int to);
        logic prev;
        for (int c = from; c <= to; c++) begin
            prev = (c == 0) ? 1'b1 : idl[c - 1];
            if (prev === 1'b1 && idl[c] === 1'b0) return c;
        end
        return -1;
    endfunction

    initial begin
        int dn;

        vectors[0] = '{8'h55, 1'b0};
        vectors[1] = '{8'h01, 1'b1};
        vectors[2] = '{8'h80, 1'b1};
        vectors[3] = '{8'h00, 1'b0};
        vectors[4] = '{8'hB7, 1'b0};
        vectors[5] = '{8'hE0, 1'b1};

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset tx",   txD,   1);
        checkOutput("reset idle", idleD, 1);
        checkOutput("reset done", doneD, 0);
        checkOutput("reset txNoPar", txN, 1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven single frames on all three configurations
        for (int i = 0; i < 6; i++) begin
            clearPlan();
            addPulse(0, vectors[i].data);
            applyStimulus(190);
            checkOutput($sformatf("vec%0d decode", i), decodeAt(trTxD, 0), int'(vectors[i].data));
            checkOutput($sformatf("vec%0d parityEven", i), trTxD[9 * OSR + 8], int'(vectors[i].parEven));
            checkOutput($sformatf("vec%0d parityOdd", i), trTxO[9 * OSR + 8], vectors[i].parEven ? 0 : 1);
            checkOutput($sformatf("vec%0d waveDefault", i),
                        waveErrs(trTxD, 0, vectors[i].data, vectors[i].parEven, 1'b1, FRAME), 0);
            checkOutput($sformatf("vec%0d waveNoPar", i),
                        waveErrs(trTxN, 0, vectors[i].data, 1'b0, 1'b0, FRAME), 0);
            checkOutput($sformatf("vec%0d idleLowDefault", i), countLow(trIdleD, 0, 189), FRAME);
            checkOutput($sformatf("vec%0d idleLowOdd", i), countLow(trIdleO, 0, 189), FRAME);
            checkOutput($sformatf("vec%0d idleLowNoPar", i), countLow(trIdleN, 0, 189), FRAME);
            checkOutput($sformatf("vec%0d doneAtEnd", i), trDoneD[FRAME], 1);
            checkOutput($sformatf("vec%0d doneCount", i), countOnes(trDoneD, 0, 189), 1);
            checkOutput($sformatf("vec%0d doneNoParAtEnd", i), trDoneN[FRAME], 1);
            checkOutput($sformatf("vec%0d doneOddCount", i), countOnes(trDoneO, 0, 189), 1);
        end

        // wrsig held high for 300 cycles: exactly one frame
        clearPlan();
        for (int k = 0; k < 300; k++) wrPlan[k] = 1'b1;
        dataPlan[0] = 8'hA3;
        applyStimulus(320);
        checkOutput("hold decode", decodeAt(trTxD, 0), 8'hA3);
        checkOutput("hold frames", frameStarts(trIdleD, 0, 319), 1);
        checkOutput("hold doneCount", countOnes(trDoneD, 0, 319), 1);
        checkOutput("hold idleAfter", countOnes(trIdleD, FRAME, 319), 320 - FRAME);

        // Second rising edge 50 cycles into a frame is dropped
        clearPlan();
        addPulse(0, 8'h12);
        addPulse(50, 8'hFF);
        applyStimulus(200);
        checkOutput("busy wave", waveErrs(trTxD, 0, 8'h12, 1'b0, 1'b1, FRAME), 0);
        checkOutput("busy frames", frameStarts(trIdleD, 0, 199), 1);
        checkOutput("busy doneCount", countOnes(trDoneD, 0, 199), 1);

        // Request on the done edge is dropped
        clearPlan();
        addPulse(0, 8'h55);
        addPulse(FRAME, 8'h0F);
        applyStimulus(200);
        checkOutput("doneEdge idleAfter", trIdleD[FRAME + 1], 1);
        checkOutput("doneEdge frames", frameStarts(trIdleD, 0, 199), 1);

        // Request one cycle after done is accepted
        clearPlan();
        addPulse(0, 8'h55);
        addPulse(FRAME + 1, 8'h0F);
        applyStimulus(370);
        checkOutput("b2b idleLow", trIdleD[FRAME + 1], 0);
        checkOutput("b2b frames", frameStarts(trIdleD, 0, 369), 2);
        checkOutput("b2b wave2", waveErrs(trTxD, FRAME + 1, 8'h0F, 1'b0, 1'b1, FRAME), 0);
        checkOutput("b2b doneCount", countOnes(trDoneD, 0, 369), 2);

        // Reset pulsed at cycle 80 of a 0x00 frame
        clearPlan();
        addPulse(0, 8'h00);
        applyStimulus(80);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset tx", txD, 1);
        checkOutput("midReset idle", idleD, 1);
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (doneD !== 1'b0) dn++;
        end
        rst_n = 1'b1;
        clearPlan();
        applyStimulus(200);
        for (int c = 0; c < 200; c++) if (trDoneD[c] !== 1'b0) dn++;
        checkOutput("midReset noDone", dn, 0);
        checkOutput("midReset staysIdle", countLow(trIdleD, 0, 199), 0);
        clearPlan();
        addPulse(0, 8'h3C);
        applyStimulus(190);
        checkOutput("afterReset wave", waveErrs(trTxD, 0, 8'h3C, 1'b0, 1'b1, FRAME), 0);
        checkOutput("afterReset decode", decodeAt(trTxD, 0), 8'h3C);
        checkOutput("afterReset doneCount", countOnes(trDoneD, 0, 189), 1);

        // Generator-style stream, one request every 255 cycles
        clearPlan();
        addPulse(0, 8'h00);
        addPulse(255, 8'h01);
        addPulse(510, 8'h02);
        applyStimulus(700);
        checkOutput("gen frames", frameStarts(trIdleD, 0, 699), 3);
        checkOutput("gen start0", findStart(trIdleD, 0, 699), 0);
        checkOutput("gen start1", findStart(trIdleD, 1, 699), 255);
        checkOutput("gen start2", findStart(trIdleD, 256, 699), 510);
        checkOutput("gen decode0", decodeAt(trTxD, 0), 8'h00);
        checkOutput("gen decode1", decodeAt(trTxD, 255), 8'h01);
        checkOutput("gen decode2", decodeAt(trTxD, 510), 8'h02);
        checkOutput("gen doneCount", countOnes(trDoneD, 0, 699), 3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
